// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM states and iteration count for the HI/LO multiply-divide unit.
// Optional divider support is selected with the MULDIV_DIV_EN macro.
package muldiv_pkg;

  localparam logic [5:0] MFHI_FUNC  = 6'b010000;
  localparam logic [5:0] MTHI_FUNC  = 6'b010001;
  localparam logic [5:0] MFLO_FUNC  = 6'b010010;
  localparam logic [5:0] MTLO_FUNC  = 6'b010011;
  localparam logic [5:0] MULT_FUNC  = 6'b011000;
  localparam logic [5:0] MULTU_FUNC = 6'b011001;
  localparam logic [5:0] DIV_FUNC   = 6'b011010;
  localparam logic [5:0] DIVU_FUNC  = 6'b011011;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
`ifdef MULDIV_DIV_EN
    ST_DIV   = 2'd2,
`endif
    ST_FIXUP = 2'd3
  } state_e;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        mode_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_i[63:32]} + {1'b0, (acc_i[0] ? operand_i : 32'd0)};
  assign mul_next = {mul_sum, acc_i[31:1]};

`ifdef MULDIV_DIV_EN
  // Divide: acc = {remainder, dividend/quotient bits}, shifting left; 33-bit trial subtract.
  logic [32:0] div_diff;
  logic [63:0] div_next;
  assign div_diff = acc_i[63:31] - {1'b0, operand_i};
  assign div_next = div_diff[32] ? {acc_i[62:0], 1'b0}
                                 : {div_diff[31:0], acc_i[30:0], 1'b1};
  assign acc_o    = mode_i ? div_next : mul_next;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign acc_o       = mul_next;
`endif

endmodule

// File: rtl/pipelined_muldiv_unit.sv
// Iterative HI/LO multiply-divide unit with pipeline stall generation.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they raise FuncError.
module pipelined_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        Start,
  input  logic [5:0]  FuncCode,
  input  logic        ReadReq,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        FuncError
);

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        div_q, div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic [63:0] acc_q, acc_d, step_acc;
  logic [31:0] opb_q, opb_d;

  logic        sgn_op;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod;

  assign sgn_op = (FuncCode == MULT_FUNC) || (FuncCode == DIV_FUNC);
  assign mag_a  = abs32(OpA, sgn_op);
  assign mag_b  = abs32(OpB, sgn_op);
  assign prod   = neg_lo_q ? (~acc_q + 64'd1) : acc_q;

  muldiv_step u_step (
    .mode_i    (div_q),
    .acc_i     (acc_q),
    .operand_i (opb_q),
    .acc_o     (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    busy_d   = busy_q;
    ferr_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (FuncCode)
            MULT_FUNC, MULTU_FUNC: begin
              acc_d    = {32'd0, mag_a};
              opb_d    = mag_b;
              neg_lo_d = sgn_op & (OpA[31] ^ OpB[31]);
              neg_hi_d = 1'b0;
              div_d    = 1'b0;
              count_d  = 6'd0;
              busy_d   = 1'b1;
              state_d  = ST_MUL;
            end
`ifdef MULDIV_DIV_EN
            DIV_FUNC, DIVU_FUNC: begin
              if (OpB == 32'd0) begin
                hi_d = OpA;
                lo_d = 32'hFFFF_FFFF;
              end else begin
                acc_d    = {32'd0, mag_a};
                opb_d    = mag_b;
                neg_lo_d = sgn_op & (OpA[31] ^ OpB[31]);
                neg_hi_d = sgn_op & OpA[31];
                div_d    = 1'b1;
                count_d  = 6'd0;
                busy_d   = 1'b1;
                state_d  = ST_DIV;
              end
            end
`endif
            MTHI_FUNC: hi_d = OpA;
            MTLO_FUNC: lo_d = OpA;
            default:   ferr_d = 1'b1;
          endcase
        end
      end
      ST_FIXUP: begin
        if (div_q) begin
          lo_d = neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
          hi_d = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        // MUL or DIV iteration; count saturates at ITER_COUNT.
        acc_d = step_acc;
        if (count_q != 6'(ITER_COUNT)) count_d = count_q + 6'd1;
        if (count_q == 6'(ITER_COUNT - 1)) state_d = ST_FIXUP;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= ST_IDLE;
      count_q  <= 6'd0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  always_ff @(posedge CLK) begin
    acc_q <= acc_d;
    opb_q <= opb_d;
  end

  assign Busy      = busy_q;
  assign Stall     = busy_q & (Start | ReadReq);
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign FuncError = ferr_q;

endmodule

// File: tb/tb_pipelined_muldiv_unit.sv
// Randomized self-checking bench for pipelined_muldiv_unit against an arithmetic HI/LO model.
module tb_pipelined_muldiv_unit;
  import muldiv_pkg::*;

  logic        CLK, Reset_L, Start, ReadReq;
  logic [5:0]  FuncCode;
  logic [31:0] OpA, OpB;
  logic        Busy, Stall, FuncError;
  logic [31:0] Hi, Lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  pipelined_muldiv_unit dut (
    .CLK(CLK), .Reset_L(Reset_L), .Start(Start), .FuncCode(FuncCode),
    .ReadReq(ReadReq), .OpA(OpA), .OpB(OpB), .Busy(Busy), .Stall(Stall),
    .Hi(Hi), .Lo(Lo), .FuncError(FuncError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one instruction given the current HI/LO.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el,
                       output int lat, output logic ef);
    longint      sa, sb;
    logic [63:0] p;
    int          q, r;
    eh = mhi; el = mlo; lat = 0; ef = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      MULT_FUNC:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; lat = 33; end
      MULTU_FUNC: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; lat = 33; end
`ifdef MULDIV_DIV_EN
      DIV_FUNC: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eh = 32'd0; el = 32'h8000_0000; lat = 33;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          eh = r; el = q; lat = 33;
        end
      end
      DIVU_FUNC: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin eh = a % b; el = a / b; lat = 33; end
      end
`endif
      MTHI_FUNC: eh = a;
      MTLO_FUNC: el = a;
      default:   ef = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int          lat, cyc;
    logic        ef;
    model(f, a, b, eh, el, lat, ef);
    @(negedge CLK);
    Start = 1'b1; FuncCode = f; OpA = a; OpB = b;
    @(negedge CLK);
    Start = 1'b0;
    check("ferr", FuncError, ef);
    cyc = 0;
    while (Busy && cyc < 40) begin
      cyc++;
      @(negedge CLK);
    end
    check("busy_cycles", cyc, lat);
    check("hi", Hi, eh);
    check("lo", Lo, el);
    mhi = eh; mlo = el;
    @(negedge CLK);
    check("ferr_clear", FuncError, 0);
    check("busy_idle", Busy, 0);
  endtask

  logic [5:0]  funcs [7] = '{MULT_FUNC, MULTU_FUNC, DIV_FUNC, DIVU_FUNC, MTHI_FUNC, MTLO_FUNC, 6'b011111};
  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] eh, el;
    int          lat, cyc, sbad;
    logic        ef;
    Reset_L = 1'b0; Start = 1'b0; ReadReq = 1'b1; FuncCode = 6'd0; OpA = 32'd0; OpB = 32'd0;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_stall", Stall, 0);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("rst_ferr", FuncError, 0);
    #12;
    ReadReq = 1'b0;
    @(negedge CLK);
    Reset_L = 1'b1;

    run_op(MULT_FUNC,  32'hFFFF_FFFF, 32'd2);
    run_op(MULTU_FUNC, 32'hFFFF_FFFF, 32'd2);
    run_op(DIV_FUNC,   32'hFFFF_FFF9, 32'd2);
    run_op(DIVU_FUNC,  32'd100, 32'd7);
    run_op(DIVU_FUNC,  32'd5, 32'd0);
    run_op(DIV_FUNC,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIV_FUNC,   32'd8, 32'd2);
    run_op(6'b011111,  32'd1, 32'd1);

    // MFLO presented at E5 of a multiply stalls until the result lands.
    model(MULT_FUNC, 32'hFFFF_FFF3, 32'd12345, eh, el, lat, ef);
    @(negedge CLK);
    Start = 1'b1; FuncCode = MULT_FUNC; OpA = 32'hFFFF_FFF3; OpB = 32'd12345;
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(negedge CLK);
    ReadReq = 1'b1;
    #1;
    check("stall_on", Stall, 1);
    sbad = 0; cyc = 0;
    while (Busy && cyc < 40) begin
      if (!Stall) sbad++;
      cyc++;
      @(negedge CLK);
    end
    check("stall_hold", sbad, 0);
    check("stall_cycles", cyc, 29);
    check("stall_release", Stall, 0);
    check("mflo_new", Lo, el);
    mhi = eh; mlo = el;
    ReadReq = 1'b0;

    // MTHI presented while busy is ignored until Busy drops, then accepted.
    model(MULTU_FUNC, 32'd1000, 32'd3000, eh, el, lat, ef);
    @(negedge CLK);
    Start = 1'b1; FuncCode = MULTU_FUNC; OpA = 32'd1000; OpB = 32'd3000;
    @(negedge CLK);
    FuncCode = MTHI_FUNC; OpA = 32'hAAAA_5555;
    #1;
    check("busy_start_stall", Stall, 1);
    cyc = 0;
    while (Busy && cyc < 40) begin
      cyc++;
      @(negedge CLK);
    end
    check("held_hi", Hi, eh);
    check("held_stall", Stall, 0);
    @(negedge CLK);
    Start = 1'b0;
    check("held_mthi", Hi, 32'hAAAA_5555);
    check("held_lo", Lo, el);
    mhi = 32'hAAAA_5555; mlo = el;

    // MTHI with a simultaneous MFHI: the read sees the old HI, no stall.
    @(negedge CLK);
    Start = 1'b1; ReadReq = 1'b1; FuncCode = MTHI_FUNC; OpA = 32'h1234_5678;
    #1;
    check("both_stall", Stall, 0);
    check("both_old_hi", Hi, mhi);
    @(negedge CLK);
    Start = 1'b0;
    check("both_new_hi", Hi, 32'h1234_5678);
    check("both_stall2", Stall, 0);
    ReadReq = 1'b0;
    mhi = 32'h1234_5678;

    // Asynchronous reset at E10 of a long operation.
    @(negedge CLK);
    Start = 1'b1;
`ifdef MULDIV_DIV_EN
    FuncCode = DIVU_FUNC;
`else
    FuncCode = MULTU_FUNC;
`endif
    OpA = 32'd1000000; OpB = 32'd7;
    @(negedge CLK);
    Start = 1'b0;
    repeat (8) @(negedge CLK);
    ReadReq = 1'b1;
    @(posedge CLK);
    #2;
    check("pre_rst_stall", Stall, 1);
    Reset_L = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_stall", Stall, 0);
    check("mid_rst_hi", Hi, 0);
    check("mid_rst_lo", Lo, 0);
    ReadReq = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    @(negedge CLK);
    Reset_L = 1'b1;
    run_op(MULTU_FUNC, 32'd3, 32'd4);

    for (int i = 0; i < 24; i++) begin
      run_op(funcs[$urandom_range(0, 6)], pick(), pick());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
